// File: rtl/neuron_frame_tx.sv
// Byte-serial transmit driver for the LIF neuron input port: serializes wide frames MSB byte first,
// pulses the neuron reset to latch weight frames, and returns the sampled spike for input frames.
module neuron_frame_tx #(
    parameter int N_STAGES = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_valid,
    output logic                       frame_ready,
    input  logic [2**N_STAGES-1:0]     frame_data,
    input  logic                       frame_is_weights,
    output logic [7:0]                 nrn_ui_in,
    output logic                       nrn_rst_n,
    input  logic                       nrn_spike,
    output logic                       spike_valid,
    output logic                       spike_out,
    output logic                       busy
);

    localparam int INPUTS = 2**N_STAGES;
    localparam int BYTES  = INPUTS / 8;
    localparam int CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SHIFT  = 3'd1;
    localparam logic [2:0] LOAD_W = 3'd2;
    localparam logic [2:0] SAMPLE = 3'd3;
    localparam logic [2:0] REPORT = 3'd4;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [INPUTS-1:0] shreg;
    logic              is_weights;

    // The bus is registered, so each edge loads the byte for the following cycle; the
    // shift register therefore always holds the bytes still to be presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            is_weights  <= 1'b0;
            frame_ready <= 1'b0;
            nrn_ui_in   <= '0;
            nrn_rst_n   <= 1'b0;
            spike_valid <= 1'b0;
            spike_out   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    nrn_rst_n <= 1'b1;
                    if (frame_valid && frame_ready) begin
                        shreg       <= frame_data << 8;
                        is_weights  <= frame_is_weights;
                        cnt         <= '0;
                        nrn_ui_in   <= frame_data[INPUTS-1 -: 8];
                        frame_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= SHIFT;
                    end else begin
                        nrn_ui_in   <= '0;
                        frame_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(BYTES - 1)) begin
                        nrn_ui_in <= '0;
                        if (is_weights) begin
                            nrn_rst_n <= 1'b0;
                            state     <= LOAD_W;
                        end else begin
                            state     <= SAMPLE;
                        end
                    end else begin
                        nrn_ui_in <= shreg[INPUTS-1 -: 8];
                        shreg     <= shreg << 8;
                    end
                end
                LOAD_W: begin
                    nrn_rst_n   <= 1'b1;
                    nrn_ui_in   <= '0;
                    frame_ready <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                SAMPLE: begin
                    nrn_ui_in   <= '0;
                    spike_out   <= nrn_spike;
                    spike_valid <= 1'b1;
                    state       <= REPORT;
                end
                REPORT: begin
                    spike_valid <= 1'b0;
                    frame_ready <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    nrn_ui_in   <= '0;
                    spike_valid <= 1'b0;
                    frame_ready <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_frame_tx.sv
// Directed self-checking bench for neuron_frame_tx at the default 64-bit frame width.
module tb_neuron_frame_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_valid;
    logic        frame_ready;
    logic [63:0] frame_data;
    logic        frame_is_weights;
    logic [7:0]  nrn_ui_in;
    logic        nrn_rst_n;
    logic        nrn_spike;
    logic        spike_valid;
    logic        spike_out;
    logic        busy;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    neuron_frame_tx #(.N_STAGES(6)) dut (
        .clk(clk),
        .reset(reset),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_data(frame_data),
        .frame_is_weights(frame_is_weights),
        .nrn_ui_in(nrn_ui_in),
        .nrn_rst_n(nrn_rst_n),
        .nrn_spike(nrn_spike),
        .spike_valid(spike_valid),
        .spike_out(spike_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one frame from IDLE and check cycles 1..12 after the accept edge.
    task automatic run_frame(input logic [63:0] d, input logic w, input logic sp,
                             input int unsigned zero_at);
        logic [7:0] exp_byte;
        frame_data       = d;
        frame_is_weights = w;
        nrn_spike        = sp;
        frame_valid      = 1'b1;
        tick();
        frame_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            exp_byte = (c <= 8) ? d[63 - 8*(c-1) -: 8] : 8'h00;
            chk($sformatf("ui_c%0d", c), 64'(nrn_ui_in), 64'(exp_byte));
            chk($sformatf("rstn_c%0d", c), 64'(nrn_rst_n), 64'(!(w && c == 9)));
            chk($sformatf("sv_c%0d", c), 64'(spike_valid), 64'(!w && c == 10));
            chk($sformatf("busy_c%0d", c), 64'(busy), 64'(w ? (c <= 9) : (c <= 10)));
            chk($sformatf("rdy_c%0d", c), 64'(frame_ready), 64'(w ? (c >= 10) : (c >= 11)));
            if (!w && c == 10) chk("spike_out", 64'(spike_out), 64'(sp));
            if (c == zero_at) frame_data = '0;
            tick();
        end
    endtask

    initial begin
        reset            = 1'b1;
        frame_valid      = 1'b0;
        frame_data       = '0;
        frame_is_weights = 1'b0;
        nrn_spike        = 1'b0;

        // Reset held for three cycles.
        repeat (3) tick();
        chk("rst_rstn", 64'(nrn_rst_n), 64'd0);
        chk("rst_rdy", 64'(frame_ready), 64'd0);
        chk("rst_ui", 64'(nrn_ui_in), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();
        chk("post_rstn", 64'(nrn_rst_n), 64'd1);
        chk("post_rdy", 64'(frame_ready), 64'd1);
        chk("post_ui", 64'(nrn_ui_in), 64'd0);
        chk("post_sv", 64'(spike_valid), 64'd0);
        chk("post_so", 64'(spike_out), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);

        // Input frame with spike high.
        run_frame(64'h0123456789ABCDEF, 1'b0, 1'b1, 0);
        chk("hold_so", 64'(spike_out), 64'd1);

        // Weight frame.
        run_frame(64'hFFFF0000FFFF0000, 1'b1, 1'b0, 0);
        chk("w_keeps_so", 64'(spike_out), 64'd1);

        // frame_data zeroed in cycle 2 must not alter the transmitted bytes.
        run_frame(64'h1122334455667788, 1'b0, 1'b0, 2);

        // Back-to-back input frames with frame_valid held high.
        frame_data       = 64'hA5A5A5A5A5A5A5A5;
        frame_is_weights = 1'b0;
        nrn_spike        = 1'b0;
        frame_valid      = 1'b1;
        tick();
        for (int c = 1; c <= 22; c++) begin
            chk($sformatf("b2b_sv_c%0d", c), 64'(spike_valid), 64'(c == 10 || c == 21));
            if (c == 10) chk("b2b_so1", 64'(spike_out), 64'd0);
            if (c == 21) chk("b2b_so2", 64'(spike_out), 64'd1);
            if (c == 11) chk("b2b_rdy", 64'(frame_ready), 64'd1);
            if (c == 12) begin
                chk("b2b_ui", 64'(nrn_ui_in), 64'hA5);
                chk("b2b_busy", 64'(busy), 64'd1);
                nrn_spike   = 1'b1;
                frame_valid = 1'b0;
            end
            tick();
        end

        // Reset asserted in cycle 4 of an input frame.
        frame_data  = 64'h0123456789ABCDEF;
        nrn_spike   = 1'b1;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_ui_c4", 64'(nrn_ui_in), 64'h67);
        reset = 1'b1;
        tick();
        chk("abort_ui", 64'(nrn_ui_in), 64'd0);
        chk("abort_rstn", 64'(nrn_rst_n), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rdy", 64'(frame_ready), 64'd0);
        chk("abort_sv", 64'(spike_valid), 64'd0);
        chk("abort_so", 64'(spike_out), 64'd0);
        reset = 1'b0;
        tick();
        chk("abort_post_rstn", 64'(nrn_rst_n), 64'd1);
        chk("abort_post_rdy", 64'(frame_ready), 64'd1);
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("abort_nosv_%0d", c), 64'(spike_valid), 64'd0);
            chk($sformatf("abort_idle_%0d", c), 64'(busy), 64'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/neuron_frame_tx.md
Name: neuron_frame_tx

Overview:
Transmit-side driver for the byte-serial LIF neuron input port. It accepts one wide input or weight frame per handshake and serializes it MSB-byte-first onto the neuron's 8-bit input bus. It issues the neuron reset pulse that latches a weight frame. It samples the neuron spike after each input frame and returns it on a one-cycle result strobe.

Parameters:
N_STAGES, 6, neuron adder-tree depth; INPUTS = 2**N_STAGES (derived localparam, must be a multiple of 8)
BYTES, INPUTS/8, derived localparam: bytes per frame (8 at default)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
frame_valid  in  1  frame offered
frame_ready  out  1  block can accept a frame
frame_data  in  INPUTS  frame bits; bit INPUTS-1 is sent first
frame_is_weights  in  1  1 = weight frame, 0 = input (spike) frame; sampled with frame_data
nrn_ui_in  out  8  byte bus to neuron ui_in
nrn_rst_n  out  1  active-low reset to neuron
nrn_spike  in  1  neuron spike output (uo_out[0])
spike_valid  out  1  one-cycle strobe: spike_out is valid
spike_out  out  1  spike sampled for the last input frame
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, frame_ready=0, nrn_ui_in=0, nrn_rst_n=0, spike_valid=0, spike_out=0, busy=0.
- nrn_rst_n stays 0 while reset is high and goes to 1 on the first clock after reset drops. frame_ready goes to 1 on that same clock.
- States: IDLE, SHIFT, LOAD_W, SAMPLE, REPORT.
- IDLE:
  - frame_ready=1 and nrn_ui_in=0.
  - Accept happens on the edge where frame_valid & frame_ready. On that edge: latch frame_data and frame_is_weights, clear byte counter cnt to 0, drop frame_ready, go to SHIFT.
- SHIFT:
  - nrn_ui_in = latched[INPUTS-1-8*cnt -: 8]. Each edge increments cnt.
  - Byte k (0-based) is on the bus during cycle k+1 after the accept edge.
  - After the edge ending byte BYTES-1, the neuron's x register equals the full frame. Next state is LOAD_W if is_weights, otherwise SAMPLE.
- LOAD_W (1 cycle):
  - nrn_rst_n=0 and nrn_ui_in=0. On this edge the neuron captures w <= x, i.e. the frame.
  - Next state is IDLE, with nrn_rst_n=1 and frame_ready=1.
  - No spike_valid is produced for weight frames.
- SAMPLE (1 cycle):
  - nrn_ui_in=0. Register spike_out <= nrn_spike and set spike_valid=1.
  - Go to REPORT.
- REPORT (1 cycle):
  - spike_valid is high in this cycle only; clear it on exit.
  - Go to IDLE with frame_ready=1.
  - spike_out holds its value until the next SAMPLE.
- Latency, accept edge = cycle 0:
  - Bytes on cycles 1..BYTES.
  - Input frame: spike_valid high in cycle BYTES+2; next accept possible at the edge ending cycle BYTES+3.
  - Weight frame: nrn_rst_n low in cycle BYTES+1; frame_ready high from cycle BYTES+2.
- No backpressure on the spike result; the consumer must take it during the strobe.
- frame_valid during a non-IDLE state is ignored and not queued; the source holds it until frame_ready.
- Reset mid-operation: abort immediately and return to reset values. No partial spike_valid is emitted. nrn_rst_n=0 also clears the neuron.
- frame_data changing after accept has no effect; only the latched copy is transmitted.
- BYTES=1 (N_STAGES=3) is legal: SHIFT lasts exactly one cycle.

Test Plan:
- Reset held 3 cycles, then released -> nrn_rst_n 0 during reset, 1 on the first post-reset cycle. frame_ready=1 and all other outputs 0 in that cycle.
- Input frame 0x0123456789ABCDEF, is_weights=0, nrn_spike tied 1 -> nrn_ui_in = 01,23,45,67,89,AB,CD,EF on cycles 1..8, then 00. spike_valid=1 only in cycle 10 with spike_out=1. busy=1 in cycles 1..10.
- Weight frame 0xFFFF0000FFFF0000, is_weights=1 -> bytes FF,FF,00,00,FF,FF,00,00 on cycles 1..8. nrn_rst_n=0 in cycle 9 only. No spike_valid. frame_ready=1 from cycle 10.
- Back-to-back input frames, frame_valid held high, nrn_spike toggles 0 then 1 -> second accept at the edge ending cycle 11. Two strobes (cycle 10 and cycle 21) with spike_out 0 then 1.
- Reset asserted in cycle 4 of a frame -> nrn_ui_in=0, nrn_rst_n=0, state IDLE after the reset edge. No spike_valid ever issued for the aborted frame.
- frame_data changed to 0 in cycle 2 -> transmitted bytes still match the frame latched at accept.
